// File: rtl/pcie_rst_pkg.sv
// pcie_rst_pkg: shared types and constants for the PCIe reset sequencer.
//   state_t      - main sequencer FSM states
//   C_*          - bit positions inside the exit-cause vector
//   CAUSE_W      - cause vector width
//   LTSSM_DET_DEF- default LTSSM code treated as an exit
package pcie_rst_pkg;

    typedef enum logic [1:0] {ST_COUNT, ST_STAGGER, ST_RUN} state_t;

    localparam int CAUSE_W  = 5;
    localparam int C_DLUP   = 0;
    localparam int C_HOTRST = 1;
    localparam int C_L2     = 2;
    localparam int C_LTSSM  = 3;
    localparam int C_FORCE  = 4;

    localparam logic [4:0] LTSSM_DET_DEF = 5'h10;

endpackage

// File: rtl/pcie_rst_stagger.sv
// pcie_rst_stagger: releases NUM_DOM reset domains in index order, STAGGER cycles apart.
//   pld_clk, any_rstn_rr - clock, async active-low reset
//   start                - release domain 0 and begin staggering
//   abort                - reassert every domain and clear progress (wins over start)
//   dom_rel              - per-domain released flag (1 = released)
//   done                 - all domains released
module pcie_rst_stagger import pcie_rst_pkg::*; #(
    parameter int NUM_DOM = 3,
    parameter int STAGGER = 8
) (
    input  logic               pld_clk,
    input  logic               any_rstn_rr,
    input  logic               start,
    input  logic               abort,
    output logic [NUM_DOM-1:0] dom_rel,
    output logic               done
);

    localparam int IDX_W = NUM_DOM > 1 ? $clog2(NUM_DOM) : 1;
    localparam int SC_W  = STAGGER > 1 ? $clog2(STAGGER) : 1;

    logic [IDX_W-1:0] idx;
    logic [SC_W-1:0]  scnt;
    logic             active;
    logic             step;

    always_comb step = active && scnt == SC_W'(STAGGER - 1);

    // idx points at the next domain to release; scnt spaces the releases.
    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr || abort) begin
            dom_rel <= '0;
            idx     <= '0;
            scnt    <= '0;
            active  <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            dom_rel <= NUM_DOM'(1);
            idx     <= IDX_W'(1);
            scnt    <= '0;
            active  <= NUM_DOM > 1;
            done    <= NUM_DOM == 1;
        end else if (step) begin
            dom_rel[idx] <= 1'b1;
            idx          <= idx + 1'b1;
            scnt         <= '0;
            if (idx == IDX_W'(NUM_DOM - 1)) begin
                active <= 1'b0;
                done   <= 1'b1;
            end
        end else if (active) begin
            scnt <= scnt + 1'b1;
        end
    end

endmodule

// File: rtl/pcie_rst_seq.sv
// pcie_rst_seq: PCIe hard-IP reset sequencer with masked exit causes and staggered domain release.
//   pld_clk, any_rstn_rr           - clock, async active-low reset
//   dlup_exit/hotrst_exit/l2_exit  - active-low exit pulses from the HIP
//   ltssm                          - HIP LTSSM state (LTSSM_DET counts as an exit)
//   force_rst                      - software reset request, level-sensitive
//   exit_mask                      - per-cause enable {force, ltssm, l2, hotrst, dlup}
//   test_sim                       - use the short simulation release threshold
//   rst_n_o                        - active-low domain resets, released in index order
//   srst, crst                     - HIP sync/config resets, active-high
//   rst_done                       - all domains released
//   exit_cnt, last_cause           - saturating exit count, masked cause of latest exit
module pcie_rst_seq import pcie_rst_pkg::*; #(
    parameter int                 NUM_DOM     = 3,
    parameter int                 CNT_W       = 11,
    parameter int                 REL_CNT     = 1024,
    parameter int                 RESTART_CNT = 1008,
    parameter int                 SIM_REL_CNT = 32,
    parameter int                 STAGGER     = 8,
    parameter int                 LTSSM_W     = 5,
    parameter logic [LTSSM_W-1:0] LTSSM_DET   = LTSSM_W'(LTSSM_DET_DEF)
) (
    input  logic               pld_clk,
    input  logic               any_rstn_rr,
    input  logic               dlup_exit,
    input  logic               hotrst_exit,
    input  logic               l2_exit,
    input  logic [LTSSM_W-1:0] ltssm,
    input  logic               force_rst,
    input  logic [CAUSE_W-1:0] exit_mask,
    input  logic               test_sim,
    output logic [NUM_DOM-1:0] rst_n_o,
    output logic               srst,
    output logic               crst,
    output logic               rst_done,
    output logic [7:0]         exit_cnt,
    output logic [CAUSE_W-1:0] last_cause
);

    logic               dlup_r, hotrst_r, l2_r;
    logic [LTSSM_W-1:0] ltssm_r;
    logic [CAUSE_W-1:0] cause, cause_r, last_cause_q;
    logic               exits_r, exits_d;
    logic [CNT_W-1:0]   cnt, thr;
    state_t             state;
    logic               hip_rst, start, done_q;
    logic [NUM_DOM-1:0] dom_rel;
    logic [7:0]         exit_cnt_q;

    always_comb begin
        cause           = '0;
        cause[C_DLUP]   = ~dlup_r;
        cause[C_HOTRST] = ~hotrst_r;
        cause[C_L2]     = ~l2_r;
        cause[C_LTSSM]  = ltssm_r == LTSSM_DET;
        cause[C_FORCE]  = force_rst;
        cause           = cause & exit_mask;
        thr             = test_sim ? CNT_W'(SIM_REL_CNT) : CNT_W'(REL_CNT);
        start           = state == ST_COUNT && cnt >= thr && !exits_r;
    end

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            dlup_r   <= 1'b1;
            hotrst_r <= 1'b1;
            l2_r     <= 1'b1;
            ltssm_r  <= '0;
            exits_r  <= 1'b0;
            cause_r  <= '0;
            exits_d  <= 1'b0;
        end else begin
            dlup_r   <= dlup_exit;
            hotrst_r <= hotrst_exit;
            l2_r     <= l2_exit;
            ltssm_r  <= ltssm;
            exits_r  <= |cause;
            cause_r  <= cause;
            exits_d  <= exits_r;
        end
    end

    // An exit beats any pending release; a held exit keeps reloading the counter.
    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            state   <= ST_COUNT;
            cnt     <= '0;
            hip_rst <= 1'b1;
        end else if (exits_r) begin
            state   <= ST_COUNT;
            cnt     <= CNT_W'(RESTART_CNT);
            hip_rst <= 1'b1;
        end else if (state == ST_COUNT) begin
            if (cnt >= thr) begin
                state   <= NUM_DOM == 1 ? ST_RUN : ST_STAGGER;
                hip_rst <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (state == ST_STAGGER && done_q) begin
            state <= ST_RUN;
        end
    end

    pcie_rst_stagger #(.NUM_DOM(NUM_DOM), .STAGGER(STAGGER)) u_stagger (
        .pld_clk     (pld_clk),
        .any_rstn_rr (any_rstn_rr),
        .start       (start),
        .abort       (exits_r),
        .dom_rel     (dom_rel),
        .done        (done_q)
    );

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            exit_cnt_q   <= '0;
            last_cause_q <= '0;
        end else if (exits_r && !exits_d) begin
            exit_cnt_q   <= exit_cnt_q + 8'(exit_cnt_q != 8'hFF);
            last_cause_q <= cause_r;
        end
    end

    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            rst_n_o    <= '0;
            srst       <= 1'b1;
            crst       <= 1'b1;
            rst_done   <= 1'b0;
            exit_cnt   <= '0;
            last_cause <= '0;
        end else begin
            rst_n_o    <= dom_rel;
            srst       <= hip_rst;
            crst       <= hip_rst;
            rst_done   <= done_q;
            exit_cnt   <= exit_cnt_q;
            last_cause <= last_cause_q;
        end
    end

endmodule

// File: tb/tb_pcie_rst_seq.sv
// tb_pcie_rst_seq: directed self-checking bench for pcie_rst_seq with default parameters.
module tb_pcie_rst_seq;

    logic       pld_clk = 1'b0;
    logic       any_rstn_rr = 1'b1;
    logic       dlup_exit = 1'b1, hotrst_exit = 1'b1, l2_exit = 1'b1;
    logic [4:0] ltssm = '0;
    logic       force_rst = 1'b0;
    logic [4:0] exit_mask = 5'h1F;
    logic       test_sim = 1'b0;
    logic [2:0] rst_n_o;
    logic       srst, crst, rst_done;
    logic [7:0] exit_cnt;
    logic [4:0] last_cause;
    int         vectors = 0;
    int         errs = 0;

    always #5 pld_clk = ~pld_clk;

    pcie_rst_seq dut (
        .pld_clk     (pld_clk),
        .any_rstn_rr (any_rstn_rr),
        .dlup_exit   (dlup_exit),
        .hotrst_exit (hotrst_exit),
        .l2_exit     (l2_exit),
        .ltssm       (ltssm),
        .force_rst   (force_rst),
        .exit_mask   (exit_mask),
        .test_sim    (test_sim),
        .rst_n_o     (rst_n_o),
        .srst        (srst),
        .crst        (crst),
        .rst_done    (rst_done),
        .exit_cnt    (exit_cnt),
        .last_cause  (last_cause)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pld_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rst_n_o"}, 32'(rst_n_o), 0);
        chk({tag, "_srst"}, 32'(srst), 1);
        chk({tag, "_crst"}, 32'(crst), 1);
        chk({tag, "_rst_done"}, 32'(rst_done), 0);
        chk({tag, "_exit_cnt"}, 32'(exit_cnt), 0);
        chk({tag, "_last_cause"}, 32'(last_cause), 0);
    endtask

    // Leaves the bench just after an edge; the next tick(n) lands on edge n after deassertion.
    task automatic do_reset(input string tag, input logic sim, input logic [4:0] mask);
        test_sim    = sim;
        exit_mask   = mask;
        any_rstn_rr = 1'b0;
        #1;
        chk_reset(tag);
        tick(3);
        any_rstn_rr = 1'b1;
    endtask

    initial begin
        tick(2);

        // Power-on release, default thresholds
        do_reset("por", 1'b0, 5'h1F);
        tick(1025);
        chk("por_1025_rst", 32'(rst_n_o), 0);
        chk("por_1025_srst", 32'(srst), 1);
        tick(1);
        chk("por_1026_rst", 32'(rst_n_o), 1);
        chk("por_1026_srst", 32'(srst), 0);
        chk("por_1026_crst", 32'(crst), 0);
        chk("por_1026_done", 32'(rst_done), 0);
        tick(7);
        chk("por_1033_rst", 32'(rst_n_o), 1);
        tick(1);
        chk("por_1034_rst", 32'(rst_n_o), 3);
        tick(7);
        chk("por_1041_rst", 32'(rst_n_o), 3);
        chk("por_1041_done", 32'(rst_done), 0);
        tick(1);
        chk("por_1042_rst", 32'(rst_n_o), 7);
        chk("por_1042_done", 32'(rst_done), 1);

        // Single-cycle hot-reset exit while running
        hotrst_exit = 1'b0;
        tick(1);
        hotrst_exit = 1'b1;
        tick(2);
        chk("hot_t2_rst", 32'(rst_n_o), 7);
        chk("hot_t2_srst", 32'(srst), 0);
        tick(1);
        chk("hot_t3_rst", 32'(rst_n_o), 0);
        chk("hot_t3_srst", 32'(srst), 1);
        chk("hot_t3_crst", 32'(crst), 1);
        chk("hot_t3_done", 32'(rst_done), 0);
        chk("hot_t3_cnt", 32'(exit_cnt), 1);
        chk("hot_t3_cause", 32'(last_cause), 5'b00010);
        tick(16);
        chk("hot_t19_rst", 32'(rst_n_o), 0);
        tick(1);
        chk("hot_t20_rst", 32'(rst_n_o), 1);
        tick(16);
        chk("hot_t36_rst", 32'(rst_n_o), 7);
        chk("hot_t36_done", 32'(rst_done), 1);

        // Masked l2 cause, then enabled LTSSM detect cause (sim threshold)
        do_reset("mask", 1'b1, 5'h1B);
        tick(33);
        chk("sim_33_rst", 32'(rst_n_o), 0);
        tick(1);
        chk("sim_34_rst", 32'(rst_n_o), 1);
        tick(16);
        chk("sim_50_rst", 32'(rst_n_o), 7);
        chk("sim_50_done", 32'(rst_done), 1);
        l2_exit = 1'b0;
        tick(1);
        l2_exit = 1'b1;
        tick(5);
        chk("mask_l2_rst", 32'(rst_n_o), 7);
        chk("mask_l2_cnt", 32'(exit_cnt), 0);
        chk("mask_l2_cause", 32'(last_cause), 0);
        ltssm = 5'h10;
        tick(1);
        ltssm = 5'h00;
        tick(2);
        chk("ltssm_t2_rst", 32'(rst_n_o), 7);
        tick(1);
        chk("ltssm_t3_rst", 32'(rst_n_o), 0);
        chk("ltssm_t3_cnt", 32'(exit_cnt), 1);
        chk("ltssm_t3_cause", 32'(last_cause), 5'b01000);
        tick(1);
        chk("ltssm_t4_rst", 32'(rst_n_o), 1);

        // dlup exit between domain 0 and domain 1 releases
        do_reset("stg", 1'b1, 5'h1F);
        tick(34);
        chk("stg_34_rst", 32'(rst_n_o), 1);
        dlup_exit = 1'b0;
        tick(1);
        dlup_exit = 1'b1;
        tick(2);
        chk("stg_37_rst", 32'(rst_n_o), 1);
        tick(1);
        chk("stg_38_rst", 32'(rst_n_o), 0);
        chk("stg_38_done", 32'(rst_done), 0);
        chk("stg_38_cause", 32'(last_cause), 5'b00001);
        tick(1);
        chk("stg_39_rst", 32'(rst_n_o), 1);
        tick(7);
        chk("stg_46_rst", 32'(rst_n_o), 1);
        tick(1);
        chk("stg_47_rst", 32'(rst_n_o), 3);
        for (int i = 48; i < 55; i++) begin
            tick(1);
            chk($sformatf("stg_%0d_done", i), 32'(rst_done), 0);
        end
        tick(1);
        chk("stg_55_rst", 32'(rst_n_o), 7);
        chk("stg_55_done", 32'(rst_done), 1);

        // Held force request for 100 cycles
        force_rst = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (i >= 3) chk($sformatf("force_%0d_rst", i), 32'(rst_n_o), 0);
        end
        chk("force_hold_srst", 32'(srst), 1);
        force_rst = 1'b0;
        tick(2);
        chk("force_f1_rst", 32'(rst_n_o), 0);
        tick(1);
        chk("force_f2_rst", 32'(rst_n_o), 1);
        chk("force_f2_cnt", 32'(exit_cnt), 2);
        chk("force_f2_cause", 32'(last_cause), 5'b10000);

        // exit_cnt saturation
        for (int i = 0; i < 300; i++) begin
            dlup_exit = 1'b0;
            tick(1);
            dlup_exit = 1'b1;
            tick(1);
        end
        tick(4);
        chk("sat_cnt", 32'(exit_cnt), 255);
        chk("sat_cause", 32'(last_cause), 5'b00001);

        // Asynchronous reset in the middle of COUNT
        test_sim  = 1'b0;
        dlup_exit = 1'b0;
        tick(1);
        dlup_exit = 1'b1;
        tick(10);
        chk("mid_rst_pre", 32'(rst_n_o), 0);
        chk("mid_cnt_pre", 32'(exit_cnt), 255);
        any_rstn_rr = 1'b0;
        #1;
        chk_reset("mid");
        tick(2);
        any_rstn_rr = 1'b1;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
